// File: rtl/pic_icsp_loader_if.sv
// ============================================================================
// Module   : pic_icsp_loader_if
// Brief    : Program-memory load port between the ICSP loader (master) and the
//            instruction memory / CPU hold logic (slave).
//            Optional macro ICSP_READBACK_EN adds the rdata return path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pic_icsp_loader_if #(
    parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
    parameter int PIC_INSTR_WIDTH        = 12
);
    logic                              program_mode;
    logic [L2_PIC_INSTR_MEM_DEPTH-1:0] waddr;
    logic [PIC_INSTR_WIDTH-1:0]        wdata;
    logic                              we;
`ifdef ICSP_READBACK_EN
    logic [PIC_INSTR_WIDTH-1:0]        rdata;
`endif

    modport master (
        output program_mode,
        output waddr,
        output wdata,
`ifdef ICSP_READBACK_EN
        input  rdata,
`endif
        output we
    );

    modport slave (
        input  program_mode,
        input  waddr,
        input  wdata,
`ifdef ICSP_READBACK_EN
        output rdata,
`endif
        input  we
    );
endinterface

`default_nettype wire

// File: rtl/pic_icsp_loader.sv
// ============================================================================
// Module   : pic_icsp_loader
// Brief    : ICSP serial front end. Decodes 6-bit commands and 16-bit data
//            frames from an external programmer and issues one-cycle writes
//            into instruction memory through the load-port interface.
//            Macro ICSP_READBACK_EN adds the READ_DATA command and the
//            icsp_dout/icsp_oe serial return path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pic_icsp_loader #(
    parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
    parameter int PIC_INSTR_WIDTH        = 12
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic prog_req,
    input  wire logic icsp_clk,
    input  wire logic icsp_data,
`ifdef ICSP_READBACK_EN
    output logic      icsp_dout,
    output logic      icsp_oe,
`endif
    pic_icsp_loader_if.master bus
);

    localparam int         c_FRAME_W = 16;
    localparam logic [4:0] c_CMD_LAST   = 5'd5;
    localparam logic [4:0] c_FRAME_LAST = 5'd15;
    localparam logic [L2_PIC_INSTR_MEM_DEPTH-1:0] c_ADDR_ONE =
        {{(L2_PIC_INSTR_MEM_DEPTH-1){1'b0}}, 1'b1};

    localparam logic [5:0] c_CMD_LOAD_DATA  = 6'h02;
    localparam logic [5:0] c_CMD_INC_ADDR   = 6'h06;
    localparam logic [5:0] c_CMD_BEGIN_PROG = 6'h08;
    localparam logic [5:0] c_CMD_RESET_ADDR = 6'h16;
`ifdef ICSP_READBACK_EN
    localparam logic [5:0] c_CMD_READ_DATA  = 6'h04;
    localparam logic [4:0] c_READ_DONE      = 5'd16;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_DECODE  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_WRITE   = 3'd4,
        S_WEND    = 3'd5,
        S_RCAP    = 3'd6,
        S_READ    = 3'd7
    } state_t;

    state_t                              r_state;
    logic [1:0]                          r_req_s;
    logic [1:0]                          r_ck_s;
    logic [1:0]                          r_dat_s;
    logic                                r_ck_d;
    logic [c_FRAME_W-1:0]                r_shift;
    logic [4:0]                          r_cnt;
    logic                                r_mode;
    logic [L2_PIC_INSTR_MEM_DEPTH-1:0]   r_waddr;
    logic [PIC_INSTR_WIDTH-1:0]          r_wdata;
    logic                                r_we;
`ifdef ICSP_READBACK_EN
    logic [c_FRAME_W-1:0]                r_rd;
    logic                                r_dout;
    logic                                r_oe;
`endif

    logic                 w_req;
    logic                 w_rise;
    logic                 w_fall;
    logic [c_FRAME_W-1:0] w_shift_nx;
    logic [5:0]           w_cmd;

    // Synchronized pins; edges are judged on the second synchronizer stage.
    assign w_req      = r_req_s[1];
    assign w_rise     = r_ck_s[1] & ~r_ck_d;
    assign w_fall     = ~r_ck_s[1] & r_ck_d;
    // Bits enter at the top so an LSB-first stream ends up right-aligned.
    assign w_shift_nx = {r_dat_s[1], r_shift[c_FRAME_W-1:1]};
    assign w_cmd      = r_shift[c_FRAME_W-1:c_FRAME_W-6];

    assign bus.program_mode = r_mode;
    assign bus.waddr        = r_waddr;
    assign bus.wdata        = r_wdata;
    assign bus.we           = r_we;
`ifdef ICSP_READBACK_EN
    assign icsp_dout = r_dout;
    assign icsp_oe   = r_oe;
`endif

    // Two-flop synchronizers for the asynchronous programmer pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_s <= 2'b00;
            r_ck_s  <= 2'b00;
            r_dat_s <= 2'b00;
            r_ck_d  <= 1'b0;
        end else begin
            r_req_s <= {r_req_s[0], prog_req};
            r_ck_s  <= {r_ck_s[0], icsp_clk};
            r_dat_s <= {r_dat_s[0], icsp_data};
            r_ck_d  <= r_ck_s[1];
        end
    end

    // Loader FSM: command/frame shifting, decode and registered load-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
`ifdef ICSP_READBACK_EN
            r_rd    <= '0;
            r_dout  <= 1'b0;
            r_oe    <= 1'b0;
`endif
        end else if ((r_state != S_IDLE) && !w_req) begin
            // Request withdrawn: discard any partial shift, keep address and data.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_we    <= 1'b0;
`ifdef ICSP_READBACK_EN
            r_oe    <= 1'b0;
            r_dout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_waddr <= '0;
                        r_mode  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        r_shift <= w_shift_nx;
                        if (r_cnt == c_CMD_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_DECODE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_DECODE: begin
                    r_cnt <= '0;
                    case (w_cmd)
                        c_CMD_LOAD_DATA:  r_state <= S_PAYLOAD;
                        c_CMD_INC_ADDR: begin
                            r_waddr <= r_waddr + c_ADDR_ONE;
                            r_state <= S_CMD;
                        end
                        c_CMD_BEGIN_PROG: r_state <= S_WRITE;
                        c_CMD_RESET_ADDR: begin
                            r_waddr <= '0;
                            r_state <= S_CMD;
                        end
`ifdef ICSP_READBACK_EN
                        c_CMD_READ_DATA:  r_state <= S_RCAP;
`endif
                        default:          r_state <= S_CMD;
                    endcase
                end
                S_PAYLOAD: begin
                    if (w_rise) begin
                        r_shift <= w_shift_nx;
                        if (r_cnt == c_FRAME_LAST) begin
                            // Frame bit 0 is a start bit; bits above the word are padding.
                            r_wdata <= w_shift_nx[PIC_INSTR_WIDTH:1];
                            r_cnt   <= '0;
                            r_state <= S_CMD;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                // Extra cycle before the strobe keeps address/data settled ahead of we.
                S_WRITE: begin
                    r_we    <= 1'b1;
                    r_state <= S_WEND;
                end
                S_WEND: begin
                    r_we    <= 1'b0;
                    r_state <= S_CMD;
                end
`ifdef ICSP_READBACK_EN
                S_RCAP: begin
                    r_rd    <= {{(c_FRAME_W-PIC_INSTR_WIDTH-1){1'b0}}, bus.rdata, 1'b0};
                    r_cnt   <= '0;
                    r_state <= S_READ;
                end
                // Present one bit per programmer rising edge; release the line on
                // the falling edge that follows the last bit.
                S_READ: begin
                    if (w_rise && (r_cnt != c_READ_DONE)) begin
                        r_dout <= r_rd[0];
                        r_rd   <= {1'b0, r_rd[c_FRAME_W-1:1]};
                        r_oe   <= 1'b1;
                        r_cnt  <= r_cnt + 5'd1;
                    end else if (w_fall && (r_cnt == c_READ_DONE)) begin
                        r_oe    <= 1'b0;
                        r_dout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_CMD;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_icsp_loader.sv
// ============================================================================
// Module   : tb_pic_icsp_loader
// Brief    : Self-checking bench for pic_icsp_loader. Write strobes are
//            checked against a scoreboard of expected {waddr, wdata} pairs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pic_icsp_loader;

    localparam int L2 = 9;
    localparam int IW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prog_req = 1'b0;
    logic icsp_clk = 1'b0;
    logic icsp_data = 1'b0;
`ifdef ICSP_READBACK_EN
    logic icsp_dout;
    logic icsp_oe;
    logic [IW-1:0] mem [0:(1<<L2)-1];
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_rise = 0;
    logic prev_we = 1'b0;
    logic [20:0] sb [$];

    pic_icsp_loader_if #(.L2_PIC_INSTR_MEM_DEPTH(L2), .PIC_INSTR_WIDTH(IW)) bus ();

    pic_icsp_loader #(.L2_PIC_INSTR_MEM_DEPTH(L2), .PIC_INSTR_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_req  (prog_req),
        .icsp_clk  (icsp_clk),
        .icsp_data (icsp_data),
`ifdef ICSP_READBACK_EN
        .icsp_dout (icsp_dout),
        .icsp_oe   (icsp_oe),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

`ifdef ICSP_READBACK_EN
    // Instruction memory model with registered read.
    always @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= bus.wdata;
        bus.rdata <= mem[bus.waddr];
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Write-strobe monitor: width, latency and scoreboard contents.
    always @(negedge clk) begin
        logic [20:0] e;
        if (bus.we === 1'b1) begin
            chk("we_width", {31'd0, prev_we}, 32'd0);
            if (!prev_we) begin
                chk("we_latency", cyc - last_rise, 5);
                if (sb.size() == 0) begin
                    chk("we_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("we_waddr", {23'd0, bus.waddr}, {23'd0, e[20:12]});
                    chk("we_wdata", {20'd0, bus.wdata}, {20'd0, e[11:0]});
                end
            end
        end
        prev_we = bus.we;
    end

    task automatic icsp_bit(input logic b);
        @(negedge clk);
        icsp_data = b;
        repeat (5) @(negedge clk);
        icsp_clk  = 1'b1;
        last_rise = cyc;
        repeat (5) @(negedge clk);
        icsp_clk  = 1'b0;
    endtask

    task automatic send_cmd(input logic [5:0] c);
        for (int i = 0; i < 6; i++) icsp_bit(c[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 0; i < 16; i++) icsp_bit(f[i]);
        repeat (2) @(negedge clk);
    endtask

    task automatic prog_word(input logic [8:0] a, input logic [11:0] d);
        sb.push_back({a, d});
        send_cmd(6'h08);
        repeat (6) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

`ifdef ICSP_READBACK_EN
    task automatic read_bit(input logic exp);
        @(negedge clk);
        icsp_data = 1'b0;
        repeat (5) @(negedge clk);
        icsp_clk = 1'b1;
        repeat (4) @(negedge clk);
        chk("rd_oe", {31'd0, icsp_oe}, 32'd1);
        chk("rd_dout", {31'd0, icsp_dout}, {31'd0, exp});
        @(negedge clk);
        icsp_clk = 1'b0;
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // T1 reset / entry
        repeat (3) @(negedge clk);
        chk("rst_mode",  {31'd0, bus.program_mode}, 0);
        chk("rst_waddr", {23'd0, bus.waddr}, 0);
        chk("rst_wdata", {20'd0, bus.wdata}, 0);
        chk("rst_we",    {31'd0, bus.we}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_mode", {31'd0, bus.program_mode}, 0);
        prog_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("entry_mode",  {31'd0, bus.program_mode}, 1);
        chk("entry_waddr", {23'd0, bus.waddr}, 0);
        chk("entry_we",    {31'd0, bus.we}, 0);

        // T2 single write
        send_cmd(6'h02);
        send_frame(16'h1FFE);
        chk("t2_wdata", {20'd0, bus.wdata}, 32'hFFF);
        prog_word(9'h000, 12'hFFF);

        // T3 increment and wrap
        send_cmd(6'h16);
        chk("t3_reset_addr", {23'd0, bus.waddr}, 0);
        for (int i = 0; i < 511; i++) send_cmd(6'h06);
        chk("t3_addr_top", {23'd0, bus.waddr}, 32'h1FF);
        chk("t3_wdata_held", {20'd0, bus.wdata}, 32'hFFF);
        send_cmd(6'h02);
        send_frame({3'b000, 12'h0A5, 1'b0});
        prog_word(9'h1FF, 12'h0A5);
        send_cmd(6'h06);
        chk("t3_wrap", {23'd0, bus.waddr}, 0);
        send_cmd(6'h06);
        chk("t3_inc", {23'd0, bus.waddr}, 1);

        // T4 abort mid-frame
        send_cmd(6'h02);
        for (int i = 0; i < 9; i++) icsp_bit(1'b1);
        @(negedge clk);
        prog_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_mode_drop", {31'd0, bus.program_mode}, 0);
        chk("t4_wdata_held", {20'd0, bus.wdata}, 32'h0A5);
        chk("t4_waddr_held", {23'd0, bus.waddr}, 1);
        repeat (10) @(negedge clk);
        chk("t4_no_we", sb.size(), 0);
        prog_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_reentry_mode", {31'd0, bus.program_mode}, 1);
        chk("t4_reentry_waddr", {23'd0, bus.waddr}, 0);

        // T5 unknown command, then write previous data
        send_cmd(6'h3F);
        chk("t5_addr", {23'd0, bus.waddr}, 0);
        chk("t5_wdata", {20'd0, bus.wdata}, 32'h0A5);
        prog_word(9'h000, 12'h0A5);

        // Padding and start bits set in the frame must not reach wdata.
        send_cmd(6'h06);
        send_cmd(6'h06);
        send_cmd(6'h02);
        send_frame(16'hEAAB);
        prog_word(9'h002, 12'h555);

`ifdef ICSP_READBACK_EN
        // T6 readback
        begin
            logic [15:0] stream;
            send_cmd(6'h16);
            for (int i = 0; i < 5; i++) send_cmd(6'h06);
            send_cmd(6'h02);
            send_frame({3'b000, 12'h3C7, 1'b0});
            prog_word(9'h005, 12'h3C7);
            send_cmd(6'h04);
            chk("t6_oe_pre", {31'd0, icsp_oe}, 0);
            stream = {3'b000, 12'h3C7, 1'b0};
            for (int i = 0; i < 16; i++) read_bit(stream[i]);
            repeat (5) @(negedge clk);
            chk("t6_oe_post", {31'd0, icsp_oe}, 0);
        end
`endif

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
